// File: rtl/stream_deserializer_if.sv
// Beat-in / word-out bundle for the stream deserializer.
// master = beat source and word consumer, slave = the deserializer itself.
interface stream_deserializer_if #(
  parameter int DATA_W = 16,
  parameter int LANE_W = 1
);
  localparam int MOD_W = $clog2(DATA_W + 1);

  logic [LANE_W-1:0] data_i;
  logic              data_val_i;
  logic              data_last_i;
  logic [DATA_W-1:0] deser_data_o;
  logic [MOD_W-1:0]  deser_data_mod_o;
  logic              deser_data_val_o;

  modport master (
    output data_i, data_val_i, data_last_i,
    input  deser_data_o, deser_data_mod_o, deser_data_val_o
  );

  modport slave (
    input  data_i, data_val_i, data_last_i,
    output deser_data_o, deser_data_mod_o, deser_data_val_o
  );
endinterface

// File: rtl/stream_deserializer.sv
// Serial-to-parallel converter: packs LANE_W-bit beats into DATA_W-bit words,
// with early close via data_last_i producing a zero-padded word and bit count.
module stream_deserializer #(
  parameter int DATA_W    = 16,
  parameter int LANE_W    = 1,
  parameter int MSB_FIRST = 1
) (
  input logic                  clk_i,
  input logic                  srst_i,
  stream_deserializer_if.slave bus
);
  localparam int BEATS = DATA_W / LANE_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int MOD_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MOD_W-1:0]  mod_q, mod_d;
  logic              val_q, val_d;
  logic [DATA_W-1:0] merged;

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      data_q <= '0;
      mod_q  <= '0;
      val_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      data_q <= data_d;
      mod_q  <= mod_d;
      val_q  <= val_d;
    end
  end

  // The accumulator is cleared on completion, so unwritten lanes stay zero.
  always_comb begin
    merged = acc_q;
    for (int k = 0; k < BEATS; k++) begin
      if (int'(cnt_q) == k) begin
        if (MSB_FIRST != 0) merged[DATA_W-1-k*LANE_W -: LANE_W] = bus.data_i;
        else                merged[k*LANE_W +: LANE_W]          = bus.data_i;
      end
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    data_d = data_q;
    mod_d  = mod_q;
    val_d  = 1'b0;
    if (bus.data_val_i) begin
      if (bus.data_last_i || cnt_q == LAST_BEAT) begin
        data_d = merged;
        mod_d  = MOD_W'((int'(cnt_q) + 1) * LANE_W);
        val_d  = 1'b1;
        cnt_d  = '0;
        acc_d  = '0;
      end else begin
        acc_d  = merged;
        cnt_d  = cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.deser_data_o     = data_q;
  assign bus.deser_data_mod_o = mod_q;
  assign bus.deser_data_val_o = val_q;
endmodule

// File: tb/tb_stream_deserializer.sv
// Drives five deserializer configurations from one shared beat stream and
// compares every DUT each cycle against a word-level reference model.
module tb_stream_deserializer;
  localparam int NDUT = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst = 1'b1;
  logic        val  = 1'b0;
  logic        last = 1'b0;
  logic [15:0] raw  = 16'h0;

  int total  = 0;
  int passed = 0;

  // Configuration of each instance: data width, lane width, MSB-first.
  int DW [NDUT] = '{16, 16, 16, 8, 8};
  int LW [NDUT] = '{ 1,  4,  4, 8, 1};
  int MF [NDUT] = '{ 1,  0,  1, 1, 1};

  int          mcnt    [NDUT];
  int          mbeats  [NDUT][16];
  logic [15:0] exp_data[NDUT];
  logic [4:0]  exp_mod [NDUT];
  logic        exp_val [NDUT];

  logic [15:0] obs_data[NDUT];
  logic [4:0]  obs_mod [NDUT];
  logic        obs_val [NDUT];

  stream_deserializer_if #(.DATA_W(16), .LANE_W(1)) if0 ();
  stream_deserializer_if #(.DATA_W(16), .LANE_W(4)) if1 ();
  stream_deserializer_if #(.DATA_W(16), .LANE_W(4)) if2 ();
  stream_deserializer_if #(.DATA_W(8),  .LANE_W(8)) if3 ();
  stream_deserializer_if #(.DATA_W(8),  .LANE_W(1)) if4 ();

  stream_deserializer #(.DATA_W(16), .LANE_W(1), .MSB_FIRST(1)) dut0 (.clk_i(clk), .srst_i(srst), .bus(if0.slave));
  stream_deserializer #(.DATA_W(16), .LANE_W(4), .MSB_FIRST(0)) dut1 (.clk_i(clk), .srst_i(srst), .bus(if1.slave));
  stream_deserializer #(.DATA_W(16), .LANE_W(4), .MSB_FIRST(1)) dut2 (.clk_i(clk), .srst_i(srst), .bus(if2.slave));
  stream_deserializer #(.DATA_W(8),  .LANE_W(8), .MSB_FIRST(1)) dut3 (.clk_i(clk), .srst_i(srst), .bus(if3.slave));
  stream_deserializer #(.DATA_W(8),  .LANE_W(1), .MSB_FIRST(1)) dut4 (.clk_i(clk), .srst_i(srst), .bus(if4.slave));

  assign if0.data_i = raw[0];
  assign if1.data_i = raw[3:0];
  assign if2.data_i = raw[3:0];
  assign if3.data_i = raw[7:0];
  assign if4.data_i = raw[0];
  assign {if0.data_val_i, if1.data_val_i, if2.data_val_i, if3.data_val_i, if4.data_val_i} = {5{val}};
  assign {if0.data_last_i, if1.data_last_i, if2.data_last_i, if3.data_last_i, if4.data_last_i} = {5{last}};

  assign obs_data[0] = if0.deser_data_o;
  assign obs_data[1] = if1.deser_data_o;
  assign obs_data[2] = if2.deser_data_o;
  assign obs_data[3] = {8'h00, if3.deser_data_o};
  assign obs_data[4] = {8'h00, if4.deser_data_o};
  assign obs_mod[0]  = if0.deser_data_mod_o;
  assign obs_mod[1]  = if1.deser_data_mod_o;
  assign obs_mod[2]  = if2.deser_data_mod_o;
  assign obs_mod[3]  = {1'b0, if3.deser_data_mod_o};
  assign obs_mod[4]  = {1'b0, if4.deser_data_mod_o};
  assign obs_val[0]  = if0.deser_data_val_o;
  assign obs_val[1]  = if1.deser_data_val_o;
  assign obs_val[2]  = if2.deser_data_val_o;
  assign obs_val[3]  = if3.deser_data_val_o;
  assign obs_val[4]  = if4.deser_data_val_o;

  // Apply one cycle of stimulus; after the edge the model holds what every
  // DUT should be showing, built from the list of beats in the current word.
  task automatic applyStimulus(input logic r, input logic v, input logic l, input logic [15:0] x);
    int w;
    srst = r; val = v; last = l; raw = x;
    @(posedge clk);
    for (int d = 0; d < NDUT; d++) begin
      if (r) begin
        mcnt[d] = 0; exp_data[d] = '0; exp_mod[d] = '0; exp_val[d] = 1'b0;
      end else begin
        exp_val[d] = 1'b0;
        if (v) begin
          mbeats[d][mcnt[d]] = int'(x) & ((1 << LW[d]) - 1);
          mcnt[d]++;
          if (l || mcnt[d] == DW[d] / LW[d]) begin
            w = 0;
            for (int i = 0; i < mcnt[d]; i++)
              w |= mbeats[d][i] << ((MF[d] != 0) ? DW[d] - (i + 1) * LW[d] : i * LW[d]);
            exp_data[d] = 16'(w);
            exp_mod[d]  = 5'(mcnt[d] * LW[d]);
            exp_val[d]  = 1'b1;
            mcnt[d]     = 0;
          end
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 4; c++) begin
      applyStimulus(c < 2, 1'b0, c == 3, 16'hFFFF);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({obs_val[d], obs_mod[d], obs_data[d]} !== 22'h0)
          $display("[TB] FAIL reset dut%0d: got val=%0b mod=%0d data=%h expected all zero", d, obs_val[d], obs_mod[d], obs_data[d]);
        else passed++;
      end
    end
  endtask

  task automatic test_serial_msb();
    logic [15:0] word;
    word = 16'hA5C3;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int b = 0; b < 18; b++) begin
      if (b < 16) applyStimulus(1'b0, 1'b1, 1'b0, {16{word[15-b]}});
      else        applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({obs_val[d], obs_mod[d], obs_data[d]} !== {exp_val[d], exp_mod[d], exp_data[d]})
          $display("[TB] FAIL serial_msb dut%0d beat%0d: got %0b/%0d/%h expected %0b/%0d/%h",
                   d, b, obs_val[d], obs_mod[d], obs_data[d], exp_val[d], exp_mod[d], exp_data[d]);
        else passed++;
      end
      if (b == 15) begin
        total++;
        if ({obs_val[0], obs_mod[0], obs_data[0]} !== {1'b1, 5'd16, 16'hA5C3})
          $display("[TB] FAIL serial_msb word: got %0b/%0d/%h expected 1/16/a5c3", obs_val[0], obs_mod[0], obs_data[0]);
        else passed++;
      end
    end
  endtask

  task automatic test_idle_gap();
    logic [3:0] beat [7] = '{4'h1, 4'h2, 4'h0, 4'h0, 4'h0, 4'h3, 4'h4};
    logic       bval [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int s = 0; s < 9; s++) begin
      if (s < 7) applyStimulus(1'b0, bval[s], 1'b0, {12'h0, beat[s]});
      else       applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({obs_val[d], obs_mod[d], obs_data[d]} !== {exp_val[d], exp_mod[d], exp_data[d]})
          $display("[TB] FAIL idle_gap dut%0d step%0d: got %0b/%0d/%h expected %0b/%0d/%h",
                   d, s, obs_val[d], obs_mod[d], obs_data[d], exp_val[d], exp_mod[d], exp_data[d]);
        else passed++;
      end
      total++;
      if (obs_val[1] !== (s == 6) || (s == 6 && {obs_mod[1], obs_data[1]} !== {5'd16, 16'h4321}))
        $display("[TB] FAIL idle_gap lsb step%0d: got %0b/%0d/%h expected pulse only at step 6 with 16/4321",
                 s, obs_val[1], obs_mod[1], obs_data[1]);
      else passed++;
    end
  endtask

  task automatic test_last_early();
    logic [3:0] beat [6] = '{4'hA, 4'hB, 4'h1, 4'h2, 4'h3, 4'h4};
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int s = 0; s < 7; s++) begin
      if (s < 6) applyStimulus(1'b0, 1'b1, s == 1, {12'h0, beat[s]});
      else       applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({obs_val[d], obs_mod[d], obs_data[d]} !== {exp_val[d], exp_mod[d], exp_data[d]})
          $display("[TB] FAIL last_early dut%0d step%0d: got %0b/%0d/%h expected %0b/%0d/%h",
                   d, s, obs_val[d], obs_mod[d], obs_data[d], exp_val[d], exp_mod[d], exp_data[d]);
        else passed++;
      end
      if (s == 1 || s == 5) begin
        total++;
        if ({obs_val[2], obs_mod[2], obs_data[2]} !== ((s == 1) ? {1'b1, 5'd8, 16'hAB00} : {1'b1, 5'd16, 16'h1234}))
          $display("[TB] FAIL last_early msb step%0d: got %0b/%0d/%h expected %s",
                   s, obs_val[2], obs_mod[2], obs_data[2], (s == 1) ? "1/8/ab00" : "1/16/1234");
        else passed++;
      end
    end
  endtask

  task automatic test_last_full();
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int s = 0; s < 9; s++) begin
      if (s < 4) applyStimulus(1'b0, 1'b1, s == 3, 16'(s + 5));
      else       applyStimulus(1'b0, 1'b0, 1'b1, 16'hFFFF);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({obs_val[d], obs_mod[d], obs_data[d]} !== {exp_val[d], exp_mod[d], exp_data[d]})
          $display("[TB] FAIL last_full dut%0d step%0d: got %0b/%0d/%h expected %0b/%0d/%h",
                   d, s, obs_val[d], obs_mod[d], obs_data[d], exp_val[d], exp_mod[d], exp_data[d]);
        else passed++;
      end
      total++;
      if (obs_val[2] !== (s == 3) || (s == 3 && {obs_mod[2], obs_data[2]} !== {5'd16, 16'h5678}))
        $display("[TB] FAIL last_full msb step%0d: got %0b/%0d/%h expected single pulse at step 3 with 16/5678",
                 s, obs_val[2], obs_mod[2], obs_data[2]);
      else passed++;
    end
  endtask

  task automatic test_reset_midword();
    logic [7:0] word;
    word = 8'h5A;
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int s = 0; s < 15; s++) begin
      if (s < 5)       applyStimulus(1'b0, 1'b1, 1'b0, {16{s[0]}});
      else if (s == 5) applyStimulus(1'b1, 1'b1, 1'b0, 16'hFFFF);
      else if (s < 14) applyStimulus(1'b0, 1'b1, 1'b0, {16{word[13-s]}});
      else             applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({obs_val[d], obs_mod[d], obs_data[d]} !== {exp_val[d], exp_mod[d], exp_data[d]})
          $display("[TB] FAIL reset_midword dut%0d step%0d: got %0b/%0d/%h expected %0b/%0d/%h",
                   d, s, obs_val[d], obs_mod[d], obs_data[d], exp_val[d], exp_mod[d], exp_data[d]);
        else passed++;
      end
      if (s == 5 || s == 13) begin
        total++;
        if ({obs_val[4], obs_mod[4], obs_data[4]} !== ((s == 5) ? {1'b0, 5'd0, 16'h0} : {1'b1, 5'd8, 16'h005A}))
          $display("[TB] FAIL reset_midword serial8 step%0d: got %0b/%0d/%h expected %s",
                   s, obs_val[4], obs_mod[4], obs_data[4], (s == 5) ? "0/0/0000" : "1/8/005a");
        else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] beat [3] = '{8'h11, 8'h22, 8'h33};
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    for (int s = 0; s < 4; s++) begin
      if (s < 3) applyStimulus(1'b0, 1'b1, 1'b0, {8'h00, beat[s]});
      else       applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({obs_val[d], obs_mod[d], obs_data[d]} !== {exp_val[d], exp_mod[d], exp_data[d]})
          $display("[TB] FAIL back_to_back dut%0d step%0d: got %0b/%0d/%h expected %0b/%0d/%h",
                   d, s, obs_val[d], obs_mod[d], obs_data[d], exp_val[d], exp_mod[d], exp_data[d]);
        else passed++;
      end
      total++;
      if (obs_val[3] !== (s < 3) || (s < 3 && {obs_mod[3], obs_data[3]} !== {5'd8, 8'h00, beat[s]}))
        $display("[TB] FAIL back_to_back word8 step%0d: got %0b/%0d/%h expected pulse=%0b",
                 s, obs_val[3], obs_mod[3], obs_data[3], s < 3);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 600; s++) begin
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 70,
                    $urandom_range(0, 99) < 12, 16'($urandom));
      for (int d = 0; d < NDUT; d++) begin
        total++;
        if ({obs_val[d], obs_mod[d], obs_data[d]} !== {exp_val[d], exp_mod[d], exp_data[d]})
          $display("[TB] FAIL random dut%0d cycle%0d: got %0b/%0d/%h expected %0b/%0d/%h",
                   d, s, obs_val[d], obs_mod[d], obs_data[d], exp_val[d], exp_mod[d], exp_data[d]);
        else passed++;
      end
    end
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) mcnt[d] = 0;
    test_reset();
    test_serial_msb();
    test_idle_gap();
    test_last_early();
    test_last_full();
    test_reset_midword();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/stream_deserializer.md
Name: stream_deserializer

Overview:
Parametrised serial-to-parallel converter. Accepts LANE_W bits per valid beat and assembles DATA_W-bit words. Bit order is selectable at elaboration time. An optional data_last_i closes a word early; the block then emits a zero-padded partial word with a valid-bit count. It sits on the receive side of serial links, feeding word-wide datapaths. There is no backpressure: the consumer must accept one word per output pulse.

Parameters:
DATA_W, 16, output word width in bits; must be a multiple of LANE_W.
LANE_W, 1, bits accepted per valid input beat; 1 <= LANE_W <= DATA_W.
MSB_FIRST, 1, 1 = first beat lands in the most-significant lane; 0 = first beat lands in the least-significant lane.

Ports:
clk_i  input  1  clock; all logic on the rising edge.
srst_i  input  1  synchronous, active-high reset.
data_i  input  LANE_W  input beat; for MSB_FIRST=1, data_i[LANE_W-1] is the most significant bit of the beat.
data_val_i  input  1  beat valid; a beat is accepted on every clock where data_val_i=1.
data_last_i  input  1  marks the accepted beat as the final beat of the word; ignored when data_val_i=0.
deser_data_o  output  DATA_W  assembled word.
deser_data_mod_o  output  $clog2(DATA_W+1)  number of valid bits in deser_data_o (LANE_W..DATA_W).
deser_data_val_o  output  1  single-cycle pulse: word outputs are valid.

Behaviour:
- Derived constant: BEATS = DATA_W/LANE_W. The internal beat counter has range 0..BEATS-1.
- Reset (srst_i=1 at a clock edge) has priority over all other inputs:
  - beat counter <= 0; shift accumulator <= 0;
  - deser_data_o <= 0; deser_data_mod_o <= 0; deser_data_val_o <= 0.
  - A partial word in progress is discarded; no pulse is emitted for it.
- Accepted beat with counter = k, MSB_FIRST=1: beat is written to bits [DATA_W-1-k*LANE_W -: LANE_W].
- Accepted beat with counter = k, MSB_FIRST=0: beat is written to bits [k*LANE_W +: LANE_W].
- Word completes on an accepted beat when counter = BEATS-1, or when data_last_i=1, or both.
- On completion, at the next clock edge:
  - deser_data_o <= accumulator including the completing beat; all lanes not written in this word are 0;
  - deser_data_mod_o <= (k+1)*LANE_W;
  - deser_data_val_o <= 1;
  - counter <= 0; accumulator <= 0.
- Latency: the valid pulse is high in cycle N+1, where N is the cycle of the completing beat.
- deser_data_o and deser_data_mod_o hold their values until the next completion or reset.
- deser_data_val_o is 0 in every cycle not directly following a completion.
- Back-to-back operation: a beat in cycle N+1 is beat 0 of the next word, with no bubble. Consecutive words give consecutive valid pulses (e.g. BEATS=1: valid every cycle).
- Idle cycles (data_val_i=0) inside a word: counter and accumulator hold; gaps of any length are allowed.
- data_last_i=1 on the beat at counter=BEATS-1: a single full word is emitted, mod=DATA_W, not two words.
- data_last_i=1 on beat 0: a single-lane word is emitted, mod=LANE_W.
- Counter wraps only through completion; it never exceeds BEATS-1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- DATA_W=16, LANE_W=1, MSB_FIRST=1: 16 consecutive beats of 0xA5C3, MSB first -> one pulse one cycle after the 16th beat; data=0xA5C3, mod=16.
- DATA_W=16, LANE_W=4, MSB_FIRST=0: beats 0x1,0x2,0x3,0x4, with data_val_i low for 3 cycles between beats 2 and 3 -> data=0x4321, mod=16, exactly one pulse.
- DATA_W=16, LANE_W=4, MSB_FIRST=1: beats 0xA,0xB with data_last_i on the 2nd beat -> data=0xAB00, mod=8; then 4 beats 0x1..0x4 -> data=0x1234, mod=16, pulses in adjacent words with no bubble.
- DATA_W=16, LANE_W=4, MSB_FIRST=1: data_last_i on the 4th beat -> exactly one pulse, mod=16. data_last_i held high while data_val_i=0 -> no pulse.
- DATA_W=8, LANE_W=1: 5 beats, then srst_i for 1 cycle -> all outputs 0, no pulse. The next 8 beats of 0x5A -> data=0x5A, mod=8.
- DATA_W=8, LANE_W=8: data_val_i high for 3 cycles with 0x11,0x22,0x33 -> pulses on 3 consecutive cycles with data 0x11,0x22,0x33, mod=8.
